// File: rtl/spi_gen_pkg.sv
// Shared definitions for the generic SPI master: FSM state encoding,
// {cpol,cpha} mode constants and default widths.
package spi_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD
    } state_t;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_NUM_CS = 4;
    localparam int DEF_DIV_W  = 16;

endpackage

// File: rtl/spi_gen_tick.sv
// Loadable down-counter: one-cycle tick every (load_val+1) enabled cycles.
// The reload value is kept as load_val itself so an all-ones divider cannot overflow.
module spi_gen_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    input  logic             en,
    output logic             tick
);
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] reload;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            reload <= '0;
        end else if (load) begin
            cnt    <= load_val;
            reload <= load_val;
        end else if (en) begin
            cnt <= (cnt == '0) ? reload : cnt - DIV_W'(1);
        end
    end

    assign tick = en && (cnt == '0);

endmodule

// File: rtl/spi_master_gen.sv
// Parametrised SPI master with start/ready handshake and all four CPOL/CPHA modes.
// Defining SPI_MASTER_GEN_BURST_EN adds hold_cs to keep a chip select low across transfers.
module spi_master_gen
    import spi_gen_pkg::*;
#(
    parameter int  DATA_W = DEF_DATA_W,
    parameter int  NUM_CS = DEF_NUM_CS,
    parameter int  DIV_W  = DEF_DIV_W,
    localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              cpol,
    input  logic              cpha,
`ifdef SPI_MASTER_GEN_BURST_EN
    input  logic              hold_cs,
`endif
    output logic              ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              sclk,
    output logic [NUM_CS-1:0] cs_n,
    output logic              mosi,
    input  logic              miso
);
    localparam int              EC_W      = $clog2(2 * DATA_W);
    localparam logic [EC_W-1:0] LAST_EDGE = EC_W'(2 * DATA_W - 1);

    state_t            state;
    state_t            state_nxt;
    logic              tick;
    logic              accept;
    logic              need_gap;
    logic              keep_cs;
    logic              gap_q;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [CS_W-1:0]   sel_q;
    logic              cpol_q;
    logic              cpha_q;
    logic [EC_W-1:0]   edge_cnt;
    logic              edge_tick;
    logic              leading;
    logic              sample_lead;
    logic              sample_now;
    logic              shift_now;

    function automatic logic [NUM_CS-1:0] sel_mask(input logic [CS_W-1:0] s);
        sel_mask = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (s == CS_W'(i)) sel_mask[i] = 1'b0;
        end
    endfunction

    assign ready  = (state == IDLE) && !gap_q;
    assign accept = start && ready;

    spi_gen_tick #(
        .DIV_W(DIV_W)
    ) u_tick (
        .clk     (clk),
        .reset   (reset),
        .load    (accept),
        .load_val(clk_div),
        .en      (state != IDLE),
        .tick    (tick)
    );

    // Even edge index = leading edge; CPHA=0 modes sample there, CPHA=1 modes shift there.
    assign edge_tick   = (state == XFER) && tick;
    assign leading     = !edge_cnt[0];
    assign sample_lead = ({cpol_q, cpha_q} == MODE0) || ({cpol_q, cpha_q} == MODE2);
    assign sample_now  = edge_tick && (leading == sample_lead);
    assign shift_now   = edge_tick && (sample_lead ? (!leading && (edge_cnt != LAST_EDGE)) : leading);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gap_q || (accept && !need_gap)) state_nxt = SETUP;
            SETUP:   if (tick) state_nxt = XFER;
            XFER:    if (tick && (edge_cnt == LAST_EDGE)) state_nxt = HOLD;
            HOLD:    if (tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // CPHA=0 preloads the word already shifted, since its MSB goes out at SETUP;
    // CPHA=1 re-presents the MSB on its first leading edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_valid <= 1'b0;
            rx_data  <= '0;
            sclk     <= 1'b0;
            cs_n     <= '1;
            mosi     <= 1'b0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            sel_q    <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            edge_cnt <= '0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    sclk <= gap_q ? cpol_q : cpol;
                    if (accept) begin
                        sel_q    <= cs_sel;
                        cpol_q   <= cpol;
                        cpha_q   <= cpha;
                        tx_sr    <= cpha ? tx_data : (tx_data << 1);
                        rx_sr    <= '0;
                        edge_cnt <= '0;
                        mosi     <= tx_data[DATA_W-1];
                        cs_n     <= need_gap ? '1 : sel_mask(cs_sel);
                    end else if (gap_q) begin
                        cs_n <= sel_mask(sel_q);
                    end
                end
                XFER: begin
                    if (tick) begin
                        sclk     <= ~sclk;
                        edge_cnt <= edge_cnt + EC_W'(1);
                        if (sample_now) rx_sr <= {rx_sr[DATA_W-2:0], miso};
                        if (shift_now) begin
                            mosi  <= tx_sr[DATA_W-1];
                            tx_sr <= tx_sr << 1;
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        rx_valid <= 1'b1;
                        rx_data  <= rx_sr;
                        mosi     <= 1'b0;
                        cs_n     <= keep_cs ? cs_n : '1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SPI_MASTER_GEN_BURST_EN
    logic            hold_q;
    logic            held_q;
    logic [CS_W-1:0] held_sel_q;

    assign need_gap = held_q && (cs_sel != held_sel_q);
    assign keep_cs  = hold_q;

    // A held line that must change target gets one deasserted IDLE cycle (gap_q) before SETUP.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q     <= 1'b0;
            held_q     <= 1'b0;
            held_sel_q <= '0;
            gap_q      <= 1'b0;
        end else begin
            gap_q <= accept && need_gap;
            if (accept) begin
                hold_q <= hold_cs;
                held_q <= 1'b0;
            end
            if ((state == HOLD) && tick) begin
                held_q     <= hold_q;
                held_sel_q <= sel_q;
            end
        end
    end
`else
    assign need_gap = 1'b0;
    assign keep_cs  = 1'b0;
    assign gap_q    = 1'b0;
`endif

endmodule

// File: doc/spi_master_gen.md
Name: spi_master_gen

Overview:
Parametrised next-generation SPI master for the serial-interface subsystem.
- Generalises data width, chip-select count and SCLK divider.
- Supports all four CPOL/CPHA modes per transfer.
- Replaces free-running pulse triggers with a start/ready handshake and a one-cycle rx_valid strobe.
- Sits between a host controller or register file and external SPI slaves.

Parameters:
DATA_W, 8, bits per transfer, ≥2, MSB first.
NUM_CS, 4, number of active-low chip selects, ≥1.
DIV_W, 16, width of the runtime half-period divider.
CS_W, $clog2(NUM_CS) (min 1), width of cs_sel; localparam.

Ports:
clk  in  1  system clock; all logic on its rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  request a transfer; accepted only when ready=1.
cs_sel  in  CS_W  target slave index; sampled at start.
tx_data  in  DATA_W  word to send; sampled at start.
clk_div  in  DIV_W  SCLK half-period = clk_div+1 clk cycles; sampled at start.
cpol  in  1  SCLK idle level; sampled at start.
cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; sampled at start.
ready  out  1  high only in IDLE.
rx_data  out  DATA_W  last received word; holds until the next rx_valid.
rx_valid  out  1  one-cycle strobe when rx_data updates.
sclk  out  1  SPI clock.
cs_n  out  NUM_CS  active-low chip selects; at most one low at a time.
mosi  out  1  serial data out; driven to 0 when idle, never Z.
miso  in  1  serial data in.

Behaviour:
- Reset values (synchronous): ready=1, rx_valid=0, rx_data=0, sclk=0, cs_n=all 1, mosi=0, state=IDLE, counters=0.
- IDLE:
  - sclk is registered from the live cpol input every cycle.
  - start && ready latches cs_sel, tx_data, clk_div (H = clk_div+1), cpol and cpha, then moves to SETUP.
  - start is ignored in every other state.
- SETUP (H cycles):
  - cs_n[cs_sel] goes low on the first SETUP cycle.
  - mosi = tx_data[DATA_W-1] from the first SETUP cycle.
  - ready=0.
- XFER (2*DATA_W*H cycles):
  - sclk toggles once every H cycles, giving 2*DATA_W edges and ending at the cpol level.
  - CPHA=0: sample miso on each leading edge; shift mosi on each trailing edge except the last.
  - CPHA=1: shift mosi on each leading edge (the first edge presents the MSB); sample miso on each trailing edge.
  - Sampling happens in the clk cycle that produces the edge. Received bits shift in MSB first.
- HOLD (H cycles): sclk = cpol; mosi holds its last bit; cs_n stays low.
- Completion, on the cycle after HOLD ends:
  - state=IDLE, ready=1, cs_n all high, mosi=0.
  - rx_valid=1 for exactly one cycle, with rx_data valid in that same cycle.
- Latency: start accepted in cycle T → rx_valid in cycle T+1+(2*DATA_W+2)*H.
- A new start may be accepted in the rx_valid cycle; SETUP then begins the next cycle.
- clk_div=0 gives H=1, so sclk = clk/2. Counters must not overflow when clk_div = all ones.
- cs_sel ≥ NUM_CS: the transfer runs with identical timing, but all cs_n stay high and rx_valid still fires.
- Changes to mode, divider or data inputs during a transfer have no effect.
- Reset mid-transfer: all outputs take their reset values on the next edge. No rx_valid is produced.

Optional Feature:
Macro SPI_MASTER_GEN_BURST_EN.
- Defined:
  - Adds input port hold_cs (1 bit), sampled at start.
  - If the latched hold_cs=1, cs_n stays low after completion and the block waits in IDLE with ready=1.
  - The next start with the same cs_sel skips re-asserting cs_n.
  - The next start with a different cs_sel deasserts the held line for one cycle before SETUP.
  - A completed transfer with hold_cs=0 releases cs_n.
  - Reset releases cs_n.
- Undefined: the hold_cs port is absent and cs_n always deasserts at completion.

Decomposition:
- Package spi_gen_pkg holds:
  - state encoding: IDLE, SETUP, XFER, HOLD;
  - SPI mode constants: MODE0..MODE3 as {cpol,cpha};
  - shared default widths.
- One sub-module, spi_gen_tick:
  - a loadable down-counter producing a one-cycle tick every H cycles while enabled;
  - the FSM uses the tick to advance states and toggle sclk.

Test Plan:
- Loopback (miso tied to mosi), DATA_W=8, clk_div=1, tx 0xA5, each of modes 0–3:
  - rx_data=0xA5;
  - rx_valid exactly at T+37;
  - sclk idles at cpol;
  - 16 sclk edges total.
- miso driven from a slave model sending 0x3C in mode 0, with tx 0xFF:
  - rx_data=0x3C;
  - mosi stays 1 throughout XFER;
  - cs_n=1110 only during SETUP through HOLD.
- clk_div=0, DATA_W=16, mode 3, tx 0x8001:
  - sclk period of 2 clk cycles;
  - rx_valid at T+35.
- start held high continuously:
  - back-to-back transfers, each accepted in the previous transfer's rx_valid cycle;
  - start pulses while busy are ignored;
  - exactly one rx_valid per transfer.
- reset asserted midway through XFER:
  - next cycle cs_n all 1, sclk=0, mosi=0, ready=1;
  - no rx_valid.
- BURST_EN: two transfers to cs_sel=2 with hold_cs=1 then 0:
  - cs_n[2] stays low continuously across both;
  - cs_n[2] rises after the second rx_valid.
